// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC multiplier and its downstream stages.
// The state encoding is shared so both FSMs decode identically on a bus view.
package cordic_pkg;

    localparam int WL    = 16;
    localparam int FL    = 14;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul10_frac.sv
// One decimal-digit extraction step: multiplies a binary fraction by ten using
// two shifts and an add, splitting the result into the new BCD digit (the
// integer part) and the remaining fraction.
module mul10_frac
    import cordic_pkg::*;
#(
    parameter int FL = cordic_pkg::FL
) (
    input  logic [FL-1:0]    f,
    output logic [BCD_W-1:0] digit,
    output logic [FL-1:0]    f_next
);

    logic [FL+3:0] t;

    // f*10 = f*8 + f*2; the upper nibble can never exceed 9 since f < 1.0
    always_comb begin
        t      = ({4'b0000, f} << 3) + ({4'b0000, f} << 1);
        digit  = t[FL+3:FL];
        f_next = t[FL-1:0];
    end

endmodule

// File: rtl/q14_to_bcd.sv
// Converts a signed Q1.14 product into sign, integer digit and N_DIG
// truncated fractional BCD digits, one fractional digit per clock.
// Uses the same start/done pulse handshake as the CORDIC multiplier.
module q14_to_bcd
    import cordic_pkg::*;
#(
    parameter int WL    = cordic_pkg::WL,
    parameter int FL    = cordic_pkg::FL,
    parameter int N_DIG = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WL-1:0]          in_q,
    output logic                   busy,
    output logic                   sign,
    output logic [BCD_W-1:0]       int_bcd,
    output logic [BCD_W*N_DIG-1:0] frac_bcd,
    output logic                   done
);

    state_t                     state;
    state_t                     state_next;

    logic                       s_q;
    logic [WL-FL:0]             int_q;
    logic [FL-1:0]              f_q;
    logic [BCD_W*N_DIG-1:0]     dig_q;
    logic [3:0]                 cnt_q;

    logic [WL:0]                in_ext;
    logic [WL:0]                mag;
    logic [BCD_W-1:0]           digit;
    logic [FL-1:0]              f_next;
    logic [BCD_W*N_DIG+3:0]     dig_shift;
    logic                       last_digit;

    mul10_frac #(
        .FL(FL)
    ) u_mul10 (
        .f      (f_q),
        .digit  (digit),
        .f_next (f_next)
    );

    // Magnitude is one bit wider than the input so -2.0 maps cleanly to +2.0
    always_comb begin
        in_ext     = {in_q[WL-1], in_q};
        mag        = in_q[WL-1] ? (~in_ext + (WL+1)'(1)) : in_ext;
        dig_shift  = {dig_q, digit};
        last_digit = (cnt_q == 4'(N_DIG - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept start only when idle, leave CONV after the last digit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operand, shift in digits MSD first, publish the result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= 1'b0;
            int_q    <= '0;
            f_q      <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            sign     <= 1'b0;
            int_bcd  <= '0;
            frac_bcd <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_q   <= in_q[WL-1];
                        int_q <= mag[WL:FL];
                        f_q   <= mag[FL-1:0];
                        dig_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CONV: begin
                    f_q   <= f_next;
                    dig_q <= dig_shift[BCD_W*N_DIG-1:0];
                    cnt_q <= cnt_q + 4'd1;
                end
                DONE: begin
                    sign     <= s_q;
                    int_bcd  <= BCD_W'(int_q);
                    frac_bcd <= dig_q;
                    done     <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    // busy reflects any non-idle state directly
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_q14_to_bcd.sv
// Directed bench for q14_to_bcd: expected results are queued when a start is
// issued and popped when done is seen.
module tb_q14_to_bcd;
    import cordic_pkg::*;

    localparam int N_DIG = 4;

    typedef struct {
        logic        sign;
        logic [3:0]  intDig;
        logic [15:0] frac;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in_q;
    logic        busy;
    logic        sign;
    logic [3:0]  int_bcd;
    logic [15:0] frac_bcd;
    logic        done;

    result_t     sb[$];
    int          checks = 0;
    int          passes = 0;
    int          fails = 0;
    int          edgeCnt = 0;
    int          e0 = 0;
    int          firstE0 = 0;
    int          busyCycles = 0;

    q14_to_bcd #(
        .WL(16),
        .FL(14),
        .N_DIG(N_DIG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_q     (in_q),
        .busy     (busy),
        .sign     (sign),
        .int_bcd  (int_bcd),
        .frac_bcd (frac_bcd),
        .done     (done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Edge counter used to measure latency from the accepting edge
    always @(posedge clk) edgeCnt++;

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: truncated decimal expansion computed arithmetically
    function automatic result_t modelRef(input logic [15:0] v);
        result_t r;
        longint  sv;
        longint  m;
        longint  fracVal;
        sv      = longint'($signed(v));
        r.sign  = (sv < 0);
        m       = (sv < 0) ? -sv : sv;
        r.intDig = 4'(m / 16384);
        fracVal = ((m % 16384) * 10000) / 16384;
        r.frac  = {4'(fracVal / 1000), 4'((fracVal / 100) % 10),
                   4'((fracVal / 10) % 10), 4'(fracVal % 10)};
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busyCycles++;
    endtask

    // Drive a one-cycle start; returns just after the accepting edge E0
    task automatic applyStimulus(input logic [15:0] val, input logic s, input logic [3:0] i,
                                 input logic [15:0] f);
        result_t r;
        r.sign   = s;
        r.intDig = i;
        r.frac   = f;
        sb.push_back(r);
        start = 1'b1;
        in_q  = val;
        @(posedge clk);
        #1;
        e0         = edgeCnt;
        busyCycles = busy ? 1 : 0;
        start      = 1'b0;
        in_q       = ~val;
    endtask

    task automatic applyModel(input logic [15:0] val);
        result_t r;
        r = modelRef(val);
        applyStimulus(val, r.sign, r.intDig, r.frac);
    endtask

    // Wait (bounded) for done, then check latency, busy width and the queued result
    task automatic waitDone(input string tag);
        result_t r;
        for (int k = 0; k < 20 && !done; k++) tick();
        checkOutput({tag, " done seen"}, 32'(done), 32'd1);
        if (done) begin
            checkOutput({tag, " latency"}, 32'(edgeCnt - e0), 32'(N_DIG + 1));
            checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(N_DIG + 1));
            if (sb.size() == 0) begin
                checkOutput({tag, " scoreboard empty"}, 32'd0, 32'd1);
            end else begin
                r = sb.pop_front();
                checkOutput({tag, " sign"}, 32'(sign), 32'(r.sign));
                checkOutput({tag, " int"}, 32'(int_bcd), 32'(r.intDig));
                checkOutput({tag, " frac"}, 32'(frac_bcd), 32'(r.frac));
            end
        end
    endtask

    initial begin
        logic sawDone;
        rst_n = 1'b0;
        start = 1'b0;
        in_q  = 16'h0000;
        tick();
        tick();
        checkOutput("reset sign", 32'(sign), 32'd0);
        checkOutput("reset int", 32'(int_bcd), 32'd0);
        checkOutput("reset frac", 32'(frac_bcd), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic conversions");
        applyStimulus(16'h2000, 1'b0, 4'd0, 16'h5000);
        waitDone("0.5");
        tick();
        checkOutput("done width", 32'(done), 32'd0);
        checkOutput("busy after done", 32'(busy), 32'd0);

        applyStimulus(16'h8000, 1'b1, 4'd2, 16'h0000);
        waitDone("-2.0");
        applyStimulus(16'hE000, 1'b1, 4'd0, 16'h5000);
        waitDone("-0.5");
        applyStimulus(16'h0000, 1'b0, 4'd0, 16'h0000);
        waitDone("zero");

        $display("[TB] truncation");
        applyStimulus(16'h7FFF, 1'b0, 4'd1, 16'h9999);
        waitDone("0x7FFF");
        applyStimulus(16'h3FFF, 1'b0, 4'd0, 16'h9999);
        waitDone("0x3FFF");
        applyStimulus(16'h0001, 1'b0, 4'd0, 16'h0000);
        waitDone("0x0001");
        applyStimulus(16'h1555, 1'b0, 4'd0, 16'h3333);
        waitDone("0x1555");

        $display("[TB] random operands against model");
        for (int n = 0; n < 4; n++) begin
            applyModel(16'($urandom));
            waitDone("random");
        end

        $display("[TB] start while busy is ignored");
        applyStimulus(16'h1000, 1'b0, 4'd0, 16'h2500);
        tick();
        start = 1'b1;
        in_q  = 16'h7FFF;
        tick();
        start = 1'b0;
        waitDone("ignored start");

        $display("[TB] start in DONE cycle is ignored");
        applyStimulus(16'h3800, 1'b0, 4'd0, 16'h8750);
        for (int k = 0; k < N_DIG; k++) tick();
        start = 1'b1;
        in_q  = 16'h2000;
        tick();
        start = 1'b0;
        waitDone("done-cycle start");
        checkOutput("busy after done-cycle start", 32'(busy), 32'd0);
        tick();
        checkOutput("busy one edge later", 32'(busy), 32'd0);

        $display("[TB] back-to-back");
        applyStimulus(16'h3000, 1'b0, 4'd0, 16'h7500);
        firstE0 = e0;
        waitDone("b2b first");
        applyStimulus(16'hF000, 1'b1, 4'd0, 16'h2500);
        checkOutput("b2b accept edge", 32'(e0 - firstE0), 32'(N_DIG + 2));
        tick();
        tick();
        checkOutput("hold frac during CONV", 32'(frac_bcd), 32'h7500);
        checkOutput("hold sign during CONV", 32'(sign), 32'd0);
        waitDone("b2b second");
        checkOutput("b2b second done edge", 32'(edgeCnt - firstE0), 32'(2 * N_DIG + 3));

        $display("[TB] reset mid-conversion");
        applyStimulus(16'h2000, 1'b0, 4'd0, 16'h5000);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort sign", 32'(sign), 32'd0);
        checkOutput("abort frac", 32'(frac_bcd), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        void'(sb.pop_back());
        #2;
        rst_n   = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            sawDone = sawDone | done;
        end
        checkOutput("no done after abort", 32'(sawDone), 32'd0);
        applyStimulus(16'h1000, 1'b0, 4'd0, 16'h2500);
        waitDone("after abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/q14_to_bcd.md
Name: q14_to_bcd

Overview:
- Downstream stage of the CORDIC multiplier.
- Takes the signed Q1.14 product and converts it into sign, integer digit and N_DIG fractional BCD digits for display/UART formatting.
- Works sequentially: one decimal digit per clock, using a shift-add ×10 step. No hardware multiplier.
- Uses the same start/done pulse handshake as the multiplier, so the multiplier's done can drive this block's start directly.

Parameters:
- WL, 16, input word length.
- FL, 14, input fractional length.
- N_DIG, 4, number of fractional decimal digits produced. Legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_q  in  WL  signed Q1.14 operand.
- busy  out  1  high whenever state is not IDLE.
- sign  out  1  1 = negative result.
- int_bcd  out  4  integer digit, 0..2.
- frac_bcd  out  4*N_DIG  fractional digits; most significant digit in the top nibble.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - sign, int_bcd, frac_bcd, done, busy all 0.
  - Internal registers cleared.
- States: IDLE, CONV, DONE.
- IDLE:
  - On a rising edge with start=1, latch s = in_q[WL-1] and mag = |in_q| as WL+1 bits, so -2.0 (0x8000) yields mag=0x8000.
  - Internal int digit = mag[WL-1:FL] (0..2); frac reg f = mag[FL-1:0]; counter cnt=0; go to CONV.
  - start=0: stay in IDLE.
- CONV, once per cycle:
  - t = (f<<3) + (f<<1), width FL+4.
  - digit = t[FL+3:FL]; always 0..9.
  - f <= t[FL-1:0].
  - Shift digit into the internal digit shift register, MSD first.
  - cnt++. When cnt==N_DIG-1, go to DONE.
- DONE:
  - Register sign=s, int_bcd, frac_bcd from the internal registers.
  - done<=1; go to IDLE.
- The next IDLE cycle drives done<=0, so done is exactly one cycle wide.
- Latency: with the start-sampling edge as E0, done is high between edges E0+N_DIG+1 and E0+N_DIG+2. For N_DIG=4, done goes high at the 5th edge after start.
- Result outputs hold their value until the next DONE. They do not change during a following CONV.
- Rounding: truncation toward zero on the magnitude. No round-half-up.
- Zero: an in_q of 0 gives sign=0. There is no negative zero.
- start while busy is ignored, not queued. in_q is sampled only at the accepting edge and may change afterwards.
- start asserted in the DONE cycle is ignored. start in the cycle after done is accepted, giving back-to-back throughput of one result every N_DIG+2 cycles.
- Reset asserted mid-CONV aborts immediately: outputs go to 0 and no done pulse is produced.
- busy is combinational from state (state!=IDLE).

Decomposition:
- Shared package cordic_pkg holds:
  - WL and FL defaults.
  - State encoding localparams: IDLE=2'd0, CONV=2'd1, DONE=2'd2, shared with the multiplier FSM.
  - BCD_W=4.
- Sub-module mul10_frac, purely combinational:
  - Input f[FL-1:0]; outputs digit[3:0] and f_next[FL-1:0].
  - Implements the shift-add ×10 step, so it can be unit-tested exhaustively over all 2^14 inputs.

Test Plan:
- Reset, then in_q=0x2000 (0.5) with a start pulse → done one cycle at E0+5; sign=0, int_bcd=0, frac_bcd=0x5000; busy high for exactly 5 cycles (E0..E0+4, the CONV and DONE states).
- in_q=0x8000 (-2.0) → sign=1, int_bcd=2, frac_bcd=0x0000. Then in_q=0xE000 (-0.5) → sign=1, int_bcd=0, frac_bcd=0x5000.
- Truncation checks:
  - in_q=0x7FFF → 1, 0x9999.
  - in_q=0x3FFF → 0, 0x9999.
  - in_q=0x0001 → 0, 0x0000.
  - in_q=0x1555 (5461/16384) → 0, 0x3333.
  - in_q=0x0000 → sign=0, 0x0000.
- start re-pulsed at E0+2 with a different in_q → ignored; result matches the first operand. Back-to-back start at E0+6 → accepted; second done at E0+11.
- rst_n pulled low at E0+2 mid-CONV → outputs 0 immediately, no done; a fresh start afterwards converts correctly.
- Chain from the multiplier: 0x2000 × 0x2000 (0.5×0.5) → multiplier out ≈0x1000, its done drives start → this block gives 0, 0x2500 (truncated; ±1 LSD tolerance for the multiplier's approximation error).
